// File: rtl/register_file.sv
// 16 x 16-bit register file with a per-register in-use scoreboard bit.
// Two combinational read ports, one writeback port with a storeNow/storeDone handshake.
module register_file (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  srcReg1,
  input  logic [3:0]  srcReg2,
  input  logic [3:0]  nextDestReg,
  input  logic [3:0]  destReg,
  input  logic [15:0] destVal,
  input  logic        storeNow,
  output logic        storeDone,
  output logic [15:0] srcRegVal1,
  output logic [15:0] srcRegVal2,
  output logic        inuse1,
  output logic        inuse2
);

  logic [15:0] r     [16];
  logic        inuse [16];

  // Register array, scoreboard and write acknowledge update.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        r[i]     <= 16'h0000;
        inuse[i] <= 1'b0;
      end
      storeDone <= 1'b0;
    end else begin
      if (storeNow) begin
        r[destReg]     <= destVal;
        inuse[destReg] <= 1'b0;
      end
      // Placed after the release so a same-register reserve wins.
      inuse[nextDestReg] <= 1'b1;
      storeDone          <= storeNow;
    end
  end

  assign srcRegVal1 = r[srcReg1];
  assign srcRegVal2 = r[srcReg2];
  assign inuse1     = inuse[srcReg1];
  assign inuse2     = inuse[srcReg2];

endmodule

// File: tb/tb_register_file.sv
// Randomized self-checking bench for register_file against an array-based model.
module tb_register_file;

  logic        clk;
  logic        rst;
  logic [3:0]  srcReg1, srcReg2, nextDestReg, destReg;
  logic [15:0] destVal;
  logic        storeNow;
  logic        storeDone;
  logic [15:0] srcRegVal1, srcRegVal2;
  logic        inuse1, inuse2;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] m_r     [16];
  logic        m_inuse [16];
  logic        m_done;

  register_file dut (
    .clk(clk), .rst(rst),
    .srcReg1(srcReg1), .srcReg2(srcReg2),
    .nextDestReg(nextDestReg), .destReg(destReg), .destVal(destVal),
    .storeNow(storeNow), .storeDone(storeDone),
    .srcRegVal1(srcRegVal1), .srcRegVal2(srcRegVal2),
    .inuse1(inuse1), .inuse2(inuse2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_value(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rs, input logic sn, input logic [3:0] dr,
                       input logic [15:0] dv, input logic [3:0] nd);
    rst = rs; storeNow = sn; destReg = dr; destVal = dv; nextDestReg = nd;
  endtask

  // Model: reset clears everything; otherwise write/release, then reserve wins.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        m_r[i] = 16'h0000;
        m_inuse[i] = 1'b0;
      end
      m_done = 1'b0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (4'(i) == nextDestReg)
          m_inuse[i] = 1'b1;
        else if (storeNow && 4'(i) == destReg)
          m_inuse[i] = 1'b0;
        if (storeNow && 4'(i) == destReg)
          m_r[i] = destVal;
      end
      m_done = storeNow;
    end
    #1;
    check_value("storeDone", {15'b0, storeDone}, {15'b0, m_done});
    for (int i = 0; i < 16; i++) begin
      check_value($sformatf("r[%0d]", i), dut.r[i], m_r[i]);
      check_value($sformatf("inuse[%0d]", i), {15'b0, dut.inuse[i]}, {15'b0, m_inuse[i]});
    end
  endtask

  task automatic read_check(input logic [3:0] s1, input logic [3:0] s2);
    srcReg1 = s1;
    srcReg2 = s2;
    #1;
    check_value("srcRegVal1", srcRegVal1, m_r[s1]);
    check_value("srcRegVal2", srcRegVal2, m_r[s2]);
    check_value("inuse1", {15'b0, inuse1}, {15'b0, m_inuse[s1]});
    check_value("inuse2", {15'b0, inuse2}, {15'b0, m_inuse[s2]});
  endtask

  initial begin
    srcReg1 = 4'd0;
    srcReg2 = 4'd0;
    // Reset with a pending write: write must be suppressed.
    drive(1'b1, 1'b1, 4'd3, 16'hAAAA, 4'd0);
    tick();
    check_value("rst_r3", dut.r[3], 16'h0000);
    check_value("rst_done", {15'b0, storeDone}, 16'h0000);
    read_check(4'd3, 4'd0);
    check_value("rst_val1", srcRegVal1, 16'h0000);
    check_value("rst_inuse1", {15'b0, inuse1}, 16'h0000);

    // Write and readback.
    drive(1'b0, 1'b1, 4'd3, 16'h0100, 4'd1);
    tick();
    check_value("wr_r3", dut.r[3], 16'h0100);
    check_value("wr_done", {15'b0, storeDone}, 16'h0001);
    read_check(4'd0, 4'd3);
    check_value("wr_val2", srcRegVal2, 16'h0100);
    check_value("wr_val1", srcRegVal1, 16'h0000);

    // Reservation.
    drive(1'b0, 1'b0, 4'd3, 16'h0100, 4'd2);
    tick();
    read_check(4'd2, 4'd4);
    check_value("res_inuse1", {15'b0, inuse1}, 16'h0001);
    check_value("res_done_fall", {15'b0, storeDone}, 16'h0000);
    drive(1'b0, 1'b0, 4'd3, 16'h0100, 4'd4);
    tick();
    check_value("res_inuse4", {15'b0, dut.inuse[4]}, 16'h0001);

    // Release.
    drive(1'b0, 1'b0, 4'd0, 16'h0000, 4'd5);
    tick();
    check_value("rel_pre", {15'b0, dut.inuse[5]}, 16'h0001);
    drive(1'b0, 1'b1, 4'd5, 16'h0080, 4'd6);
    tick();
    check_value("rel_r5", dut.r[5], 16'h0080);
    check_value("rel_inuse5", {15'b0, dut.inuse[5]}, 16'h0000);
    check_value("rel_done", {15'b0, storeDone}, 16'h0001);

    // Collision: reserve wins over release.
    drive(1'b0, 1'b1, 4'd7, 16'hBEEF, 4'd7);
    tick();
    check_value("col_r7", dut.r[7], 16'hBEEF);
    check_value("col_inuse7", {15'b0, dut.inuse[7]}, 16'h0001);

    // Handshake fall.
    drive(1'b0, 1'b0, 4'd7, 16'h1234, 4'd8);
    tick();
    check_value("hs_done", {15'b0, storeDone}, 16'h0000);
    check_value("hs_r7", dut.r[7], 16'hBEEF);
    check_value("hs_inuse8", {15'b0, dut.inuse[8]}, 16'h0001);

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 400; c++) begin
      drive(($urandom_range(0, 24) == 0) ? 1'b1 : 1'b0,
            1'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)),
            16'($urandom),
            4'($urandom_range(0, 15)));
      read_check(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      tick();
    end
    read_check(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
